// File: rtl/matrix_alu_pkg.sv
// matrix_alu_pkg: shared state encoding, ALU register offsets and opcodes for the matrix ALU sequencer
package matrix_alu_pkg;
    typedef enum logic [2:0] {IDLE, WR_SRC1, WR_SRC2, WR_OP, WAIT, RD_RES, RESP} state_e;
    localparam logic [11:0] SRC1       = 12'h000;
    localparam logic [11:0] SRC2       = 12'h001;
    localparam logic [11:0] RESULT     = 12'h002;
    localparam logic [11:0] STATUS_IN  = 12'h003;
    localparam logic [11:0] STATUS_OUT = 12'h004;
    localparam logic [7:0]  MATRIX_ADD = 8'h01;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin arbiter; a tie goes to the requester not granted last
module rr_arbiter_2 (
    input  logic       Clk,
    input  logic       nReset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);
    logic prio_q, prio_d;
    always_comb begin
        grant  = (req == 2'b11) ? (prio_q ? 2'b10 : 2'b01) : req;
        prio_d = (advance && |grant) ? grant[0] : prio_q;
    end
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) prio_q <= 1'b0;
        else         prio_q <= prio_d;
    end
endmodule

// File: rtl/matrix_alu_sequencer.sv
// matrix_alu_sequencer: arbitrates two requesters and runs write-src1/src2/opcode, wait, read-result on the matrix ALU bus
module matrix_alu_sequencer
    import matrix_alu_pkg::*;
#(
    parameter int         WAIT_CYCLES = 2,
    parameter logic [3:0] ALU_BASE    = 4'h2
) (
    input  logic         Clk,
    input  logic         nReset,
    input  logic [1:0]   ReqValid,
    output logic [1:0]   ReqReady,
    input  logic [511:0] ReqOpA,
    input  logic [511:0] ReqOpB,
    input  logic [15:0]  ReqOpcode,
    output logic         RespValid,
    input  logic         RespReady,
    output logic         RespId,
    output logic         RespErr,
    output logic [255:0] RespData,
    output logic [15:0]  address,
    output logic         nWrite,
    output logic         nRead,
    output logic [255:0] ExeDataOut,
    input  logic [255:0] MatrixDataOut
);
    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [255:0]   opa_q, opb_q, data_q;
    logic [7:0]     opc_q;
    logic           id_q, err_q, run_q;
    logic [1:0]     grant;
    logic           accept, sel;
    logic [7:0]     opc_sel;

    rr_arbiter_2 u_arb (
        .Clk    (Clk),
        .nReset (nReset),
        .req    (ReqValid),
        .advance(accept),
        .grant  (grant)
    );

    // run_q keeps ReqReady low while reset is held, without using nReset as data
    assign ReqReady  = (state_q == IDLE && run_q) ? grant : 2'b00;
    assign accept    = |ReqReady;
    assign sel       = grant[1];
    assign opc_sel   = sel ? ReqOpcode[15:8] : ReqOpcode[7:0];
    assign RespValid = (state_q == RESP);
    assign RespId    = RespValid & id_q;
    assign RespErr   = RespValid & err_q;
    assign RespData  = RespValid ? data_q : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:    if (accept) state_d = (opc_sel == MATRIX_ADD) ? WR_SRC1 : RESP;
            WR_SRC1: state_d = WR_SRC2;
            WR_SRC2: state_d = WR_OP;
            WR_OP: begin
                state_d = WAIT;
                cnt_d   = 4'(WAIT_CYCLES);
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RD_RES;
            end
            RD_RES:  state_d = RESP;
            RESP:    if (RespReady) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        address    = 16'h0000;
        nWrite     = 1'b1;
        nRead      = 1'b1;
        ExeDataOut = '0;
        case (state_q)
            WR_SRC1: begin
                address    = {ALU_BASE, SRC1};
                nWrite     = 1'b0;
                ExeDataOut = opa_q;
            end
            WR_SRC2: begin
                address    = {ALU_BASE, SRC2};
                nWrite     = 1'b0;
                ExeDataOut = opb_q;
            end
            WR_OP: begin
                address    = {ALU_BASE, STATUS_IN};
                nWrite     = 1'b0;
                ExeDataOut = {248'b0, opc_q};
            end
            RD_RES: begin
                address = {ALU_BASE, RESULT};
                nRead   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            opa_q   <= '0;
            opb_q   <= '0;
            opc_q   <= 8'h00;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
            if (accept) begin
                opa_q  <= sel ? ReqOpA[511:256] : ReqOpA[255:0];
                opb_q  <= sel ? ReqOpB[511:256] : ReqOpB[255:0];
                opc_q  <= opc_sel;
                id_q   <= sel;
                err_q  <= (opc_sel != MATRIX_ADD);
                data_q <= '0;
            end
            if (state_q == RD_RES) data_q <= MatrixDataOut;
        end
    end
endmodule

// File: tb/tb_matrix_alu_sequencer.sv
// tb_matrix_alu_sequencer: directed checks of arbitration, bus sequencing, errors, backpressure and reset
module tb_matrix_alu_sequencer;
    logic         Clk = 1'b0, nReset = 1'b0, RespReady = 1'b0;
    logic [1:0]   ReqValid = 2'b00, ReqValid1 = 2'b00;
    logic [511:0] ReqOpA = '0, ReqOpB = '0;
    logic [15:0]  ReqOpcode = '0;
    logic [1:0]   ReqReady, ReqReady1;
    logic         RespValid, RespId, RespErr, nWrite, nRead;
    logic         RespValid1, RespId1, RespErr1, nWrite1, nRead1;
    logic [255:0] RespData, ExeDataOut, MatrixDataOut, RespData1, ExeDataOut1, MatrixDataOut1;
    logic [15:0]  address, address1;
    logic [255:0] s1, s2, t1, t2;
    logic [7:0]   op0 = 8'h00, op1 = 8'h00;
    int           vectors = 0, errors = 0, bus_acts = 0, both_low = 0;

    localparam logic [255:0] A1 = {16{16'h0001}}, B2 = {16{16'h0002}}, S3 = {16{16'h0003}};
    localparam logic [255:0] A10 = {16{16'h0010}}, B100 = {16{16'h0100}}, S110 = {16{16'h0110}};
    localparam logic [255:0] A20 = {16{16'h0020}}, B7 = {16{16'h0007}}, S27 = {16{16'h0027}};

    matrix_alu_sequencer dut (
        .Clk(Clk), .nReset(nReset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOpA(ReqOpA), .ReqOpB(ReqOpB), .ReqOpcode(ReqOpcode),
        .RespValid(RespValid), .RespReady(RespReady), .RespId(RespId), .RespErr(RespErr),
        .RespData(RespData), .address(address), .nWrite(nWrite), .nRead(nRead),
        .ExeDataOut(ExeDataOut), .MatrixDataOut(MatrixDataOut)
    );

    matrix_alu_sequencer #(.WAIT_CYCLES(1)) dut1 (
        .Clk(Clk), .nReset(nReset), .ReqValid(ReqValid1), .ReqReady(ReqReady1),
        .ReqOpA(ReqOpA), .ReqOpB(ReqOpB), .ReqOpcode(ReqOpcode),
        .RespValid(RespValid1), .RespReady(RespReady), .RespId(RespId1), .RespErr(RespErr1),
        .RespData(RespData1), .address(address1), .nWrite(nWrite1), .nRead(nRead1),
        .ExeDataOut(ExeDataOut1), .MatrixDataOut(MatrixDataOut1)
    );

    always #5 Clk = ~Clk;

    function automatic logic [255:0] lane_add(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
        return r;
    endfunction

    // Behavioural matrix ALU, one per DUT: latches writes, returns lane-wise sums on a result read
    always @(posedge Clk) begin
        if (!nWrite && address == 16'h2000) s1 <= ExeDataOut;
        if (!nWrite && address == 16'h2001) s2 <= ExeDataOut;
        if (!nWrite && address == 16'h2003) op0 <= ExeDataOut[7:0];
        if (!nWrite1 && address1 == 16'h2000) t1 <= ExeDataOut1;
        if (!nWrite1 && address1 == 16'h2001) t2 <= ExeDataOut1;
        if (!nWrite1 && address1 == 16'h2003) op1 <= ExeDataOut1[7:0];
    end
    assign MatrixDataOut  = (!nRead && address == 16'h2002 && op0 == 8'h01) ? lane_add(s1, s2) : '0;
    assign MatrixDataOut1 = (!nRead1 && address1 == 16'h2002 && op1 == 8'h01) ? lane_add(t1, t2) : '0;

    always @(negedge Clk) begin
        if (!nWrite || !nRead) bus_acts++;
        if (!nWrite && !nRead) both_low++;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input int r, input logic [255:0] a, input logic [255:0] b, input logic [7:0] op, output bit ok);
        int n = 0;
        ReqOpA[r*256 +: 256] = a;
        ReqOpB[r*256 +: 256] = b;
        ReqOpcode[r*8 +: 8]  = op;
        ReqValid[r]          = 1'b1;
        #1;
        while (!ReqReady[r] && n < 40) begin
            tick();
            n++;
        end
        ok = ReqReady[r];
        tick();
        ReqValid[r] = 1'b0;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        while (!RespValid && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic drain;
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
    endtask

    task automatic test_reset;
        ReqValid = 2'b11;
        nReset   = 1'b0;
        tick();
        tick();
        vectors++;
        if (ReqReady !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", ReqReady); end
        vectors++;
        if ({RespValid, RespId, RespErr} !== 3'b000) begin errors++; $display("FAIL reset_resp: got %b want 000", {RespValid, RespId, RespErr}); end
        vectors++;
        if ({nWrite, nRead, address} !== {2'b11, 16'h0000}) begin errors++; $display("FAIL reset_bus: got %b %b %h want 1 1 0000", nWrite, nRead, address); end
        vectors++;
        if ({RespData, ExeDataOut} !== 512'b0) begin errors++; $display("FAIL reset_data: got %h %h want 0", RespData, ExeDataOut); end
        ReqValid = 2'b00;
        nReset   = 1'b1;
        tick();
    endtask

    task automatic test_contention;
        int n;
        logic exp;
        ReqOpA    = {A10, A1};
        ReqOpB    = {B100, B2};
        ReqOpcode = 16'h0101;
        ReqValid  = 2'b11;
        for (int k = 0; k < 3; k++) begin
            exp = (k == 1);
            n   = 0;
            #1;
            while (ReqReady == 2'b00 && n < 40) begin
                tick();
                n++;
            end
            vectors++;
            if (ReqReady !== (exp ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", k, ReqReady, exp ? 2'b10 : 2'b01); end
            tick();
            wait_resp(n);
            vectors++;
            if (n != 6) begin errors++; $display("FAIL contention_latency%0d: got %0d want 7", k, n + 1); end
            vectors++;
            if ({RespId, RespErr, RespData, ReqReady} !== {exp, 1'b0, exp ? S110 : S3, 2'b00}) begin
                errors++;
                $display("FAIL contention_resp%0d: got id=%b err=%b ready=%b data=%h want id=%b", k, RespId, RespErr, ReqReady, RespData, exp);
            end
            drain();
        end
        ReqValid = 2'b00;
    endtask

    task automatic test_single_add;
        bit ok;
        int n;
        issue(0, A1, B2, 8'h01, ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL add_accept: got no ReqReady want 01"); end
        vectors++;
        if ({RespValid, address, nWrite, nRead, ExeDataOut} !== {1'b0, 16'h2000, 2'b01, A1}) begin errors++; $display("FAIL add_src1: got %h %b%b %h", address, nWrite, nRead, ExeDataOut); end
        tick();
        vectors++;
        if ({RespValid, address, nWrite, nRead, ExeDataOut} !== {1'b0, 16'h2001, 2'b01, B2}) begin errors++; $display("FAIL add_src2: got %h %b%b %h", address, nWrite, nRead, ExeDataOut); end
        tick();
        vectors++;
        if ({RespValid, address, nWrite, nRead, ExeDataOut} !== {1'b0, 16'h2003, 2'b01, 248'b0, 8'h01}) begin errors++; $display("FAIL add_op: got %h %b%b %h", address, nWrite, nRead, ExeDataOut); end
        for (int c = 4; c < 6; c++) begin
            tick();
            vectors++;
            if ({RespValid, address, nWrite, nRead, ExeDataOut} !== {1'b0, 16'h0000, 2'b11, 256'b0}) begin errors++; $display("FAIL add_wait%0d: got %h %b%b %h", c, address, nWrite, nRead, ExeDataOut); end
        end
        tick();
        vectors++;
        if ({RespValid, address, nWrite, nRead, ExeDataOut} !== {1'b0, 16'h2002, 2'b10, 256'b0}) begin errors++; $display("FAIL add_read: got v=%b %h %b%b", RespValid, address, nWrite, nRead); end
        tick();
        vectors++;
        if ({RespValid, RespId, RespErr, RespData} !== {3'b100, S3}) begin errors++; $display("FAIL add_resp: got v=%b id=%b err=%b data=%h want 1 0 0 %h", RespValid, RespId, RespErr, RespData, S3); end
        drain();
        vectors++;
        if (RespValid !== 1'b0) begin errors++; $display("FAIL add_release: got %b want 0", RespValid); end
        n = 0;
    endtask

    task automatic test_bad_opcode;
        bit ok;
        int n, a;
        a = bus_acts;
        issue(0, A1, B2, 8'h11, ok);
        wait_resp(n);
        vectors++;
        if (!ok || n != 0) begin errors++; $display("FAIL bad_latency: got %0d want 1", n + 1); end
        vectors++;
        if ({RespValid, RespErr, RespId, RespData} !== {3'b110, 256'b0}) begin errors++; $display("FAIL bad_resp: got v=%b err=%b id=%b data=%h want 1 1 0 0", RespValid, RespErr, RespId, RespData); end
        drain();
        vectors++;
        if (bus_acts != a) begin errors++; $display("FAIL bad_bus: got %0d strobe cycles want 0", bus_acts - a); end
    endtask

    task automatic test_backpressure;
        bit ok;
        int n;
        issue(1, A10, B100, 8'h01, ok);
        wait_resp(n);
        vectors++;
        if (!ok || n != 6) begin errors++; $display("FAIL bp_latency: got %0d want 7", n + 1); end
        ReqOpA[255:0]  = A1;
        ReqOpcode[7:0] = 8'h11;
        ReqValid[0]    = 1'b1;
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if ({RespValid, RespId, RespErr, RespData, ReqReady} !== {3'b110, S110, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold%0d: got v=%b id=%b err=%b ready=%b data=%h", c, RespValid, RespId, RespErr, ReqReady, RespData);
            end
            tick();
        end
        drain();
        vectors++;
        if (ReqReady !== 2'b01) begin errors++; $display("FAIL bp_next_ready: got %b want 01", ReqReady); end
        tick();
        ReqValid[0] = 1'b0;
        wait_resp(n);
        vectors++;
        if ({n == 0, RespErr, RespId} !== 3'b110) begin errors++; $display("FAIL bp_next_resp: got lat=%0d err=%b id=%b want 1 1 0", n + 1, RespErr, RespId); end
        drain();
    endtask

    task automatic test_reset_in_wait;
        bit ok;
        int n, seen = 0;
        issue(0, A1, B2, 8'h01, ok);
        tick();
        tick();
        tick();
        nReset = 1'b0;
        #1;
        vectors++;
        if ({RespValid, ReqReady, nWrite, nRead, address, ExeDataOut} !== {3'b000, 2'b11, 16'h0000, 256'b0}) begin
            errors++;
            $display("FAIL rst_wait_outputs: got v=%b ready=%b %b%b %h", RespValid, ReqReady, nWrite, nRead, address);
        end
        #2;
        nReset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (RespValid) seen++;
        end
        vectors++;
        if (seen != 0) begin errors++; $display("FAIL rst_wait_noresp: got %0d response cycles want 0", seen); end
        issue(1, A20, B7, 8'h01, ok);
        vectors++;
        if ({ok, address, nWrite, ExeDataOut} !== {1'b1, 16'h2000, 1'b0, A20}) begin errors++; $display("FAIL rst_wait_restart: got ok=%b %h %b %h", ok, address, nWrite, ExeDataOut); end
        wait_resp(n);
        vectors++;
        if ({n == 6, RespId, RespErr, RespData} !== {3'b110, S27}) begin errors++; $display("FAIL rst_wait_resp: got lat=%0d id=%b err=%b data=%h", n + 1, RespId, RespErr, RespData); end
        drain();
    endtask

    task automatic test_wait1;
        int n = 0;
        ReqOpA[255:0]  = A1;
        ReqOpB[255:0]  = B2;
        ReqOpcode[7:0] = 8'h01;
        ReqValid1      = 2'b01;
        #1;
        vectors++;
        if (ReqReady1 !== 2'b01) begin errors++; $display("FAIL w1_ready: got %b want 01", ReqReady1); end
        tick();
        ReqValid1 = 2'b00;
        while (!RespValid1 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n != 5) begin errors++; $display("FAIL w1_latency: got %0d want 6", n + 1); end
        vectors++;
        if ({RespId1, RespErr1, RespData1} !== {2'b00, S3}) begin errors++; $display("FAIL w1_resp: got id=%b err=%b data=%h", RespId1, RespErr1, RespData1); end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_contention();
        test_single_add();
        test_bad_opcode();
        test_backpressure();
        test_reset_in_wait();
        test_wait1();
        vectors++;
        if (both_low != 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles want 0", both_low); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/matrix_alu_sequencer.md
MATRIX_ALU_SEQUENCER -- requirements
Module: matrix_alu_sequencer

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, meaning idle cycles between the opcode write and the result read (legal range 1..15).
REQ-002 Parameter ALU_BASE, default 4'h2, meaning the matrix ALU select value driven on address[15:12].
REQ-003 Port Clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port nReset  in  1  reset, asynchronous, active-low.
REQ-005 Port ReqValid  in  2  per-requester command valid, index 0 and 1.
REQ-006 Port ReqReady  out  2  per-requester command accept, at most one bit high.
REQ-007 Port ReqOpA  in  2x256  per-requester source-1 matrix word.
REQ-008 Port ReqOpB  in  2x256  per-requester source-2 matrix word.
REQ-009 Port ReqOpcode  in  2x8  per-requester ALU opcode.
REQ-010 Port RespValid  out  1  response available.
REQ-011 Port RespReady  in  1  response consumed.
REQ-012 Port RespId  out  1  requester index owning the response.
REQ-013 Port RespErr  out  1  opcode rejected, no ALU access performed.
REQ-014 Port RespData  out  256  result word, zero when RespErr=1.
REQ-015 Port address  out  16  ALU register address.
REQ-016 Port nWrite  out  1  ALU write strobe, active-low.
REQ-017 Port nRead  out  1  ALU read strobe, active-low.
REQ-018 Port ExeDataOut  out  256  write data to the ALU.
REQ-019 Port MatrixDataOut  in  256  result data from the ALU.

Function
REQ-020 FSM states SHALL be IDLE, WR_SRC1, WR_SRC2, WR_OP, WAIT, RD_RES, RESP; each state except WAIT and RESP SHALL last exactly one cycle.
REQ-021 ReqReady SHALL be asserted combinationally only in IDLE, and only for the arbitration winner.
REQ-022 Arbitration SHALL be round-robin: with one valid requester, grant it; with both valid, grant the one not granted last; after reset, requester 0 wins a tie.
REQ-023 On accept (ReqValid&ReqReady), the controller SHALL latch the winner's OpA, OpB, Opcode and index.
REQ-024 Bus ops: WR_SRC1 drives {ALU_BASE,12'h000}, nWrite=0, ExeDataOut=OpA. WR_SRC2 drives 12'h001 with OpB. WR_OP drives 12'h003 with {248'b0,Opcode}.
REQ-025 WAIT SHALL hold the bus idle for exactly WAIT_CYCLES cycles using a 4-bit down-counter.
REQ-026 RD_RES SHALL drive 12'h002 with nRead=0 and capture MatrixDataOut at the cycle-ending edge.
REQ-027 When the bus is idle, the controller SHALL drive nWrite=1, nRead=1, address=0 and ExeDataOut=0; nWrite and nRead SHALL never be low together.
REQ-028 Latency: with accept at cycle 0, RespValid SHALL rise at cycle 5+WAIT_CYCLES (cycle 7 at default).
REQ-029 An opcode other than 8'h01 SHALL skip all bus states; the controller SHALL go IDLE->RESP with RespErr=1 and RespData=0, so RespValid rises at cycle 1.
REQ-030 RESP SHALL hold RespValid, RespId, RespErr and RespData stable until RespReady=1, then return to IDLE; ReqReady SHALL stay 0 throughout.
REQ-031 A request arriving while busy SHALL wait; the requester SHALL hold ReqValid and its data stable until ReqReady.

Reset
REQ-032 nReset low SHALL asynchronously force: state IDLE, every output 0 except nWrite=1 and nRead=1, the round-robin pointer to favour requester 0, and the WAIT counter to 0.
REQ-033 Reset asserted mid-sequence SHALL abort the operation with no response; the first command after release restarts at WR_SRC1.

Structure
REQ-034 Package matrix_alu_pkg SHALL hold the state enum, the register offsets SRC1=0, SRC2=1, RESULT=2, STATUS_IN=3, STATUS_OUT=4, and MATRIX_ADD=8'h01.
REQ-035 Round-robin logic SHALL live in sub-module rr_arbiter_2 (inputs req[1:0] and advance; output grant[1:0]).

Verification
REQ-036 Single add: requester 0 sends OpA with every 16-bit lane 16'h0001, OpB with every lane 16'h0002, opcode 8'h01 -> bus sequence 2000,2001,2003, 2 idle cycles, 2002; RespData = model sum; RespId=0; RespValid at cycle 7.
REQ-037 Contention: both requesters valid in the same cycle, twice back-to-back -> grants go 0 then 1 then 0; responses are in grant order.
REQ-038 Bad opcode: opcode 8'h11 -> no nWrite/nRead activity; RespErr=1 and RespData=0 at cycle 1.
REQ-039 Backpressure: RespReady held low for 5 cycles -> response stays stable and ReqReady stays 0 for those 5 cycles.
REQ-040 Reset in WAIT: nReset pulsed low -> outputs take reset values immediately with no response; the next command completes normally.
REQ-041 WAIT_CYCLES=1 -> RespValid at cycle 6.
